// File: rtl/fpga_robots_game_ticks.sv
// fpga_robots_game_ticks
//   Multi-channel timing-pulse generator for the 65MHz game clock. Each
//   channel is a phase accumulator with a runtime-programmable step and
//   post-divider. It produces the following outputs:
//     - a base tick on accumulator carry;
//     - a 2^SUB_SHIFT-times faster sub-tick;
//     - a divided tick;
//     - a toggle.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   wr_en     load wr_step/wr_div into channel wr_sel this cycle
//   wr_sel    channel to load (values >= NCHAN are ignored)
//   wr_step   new accumulator step
//   wr_div    new post-divider (period = wr_div+1 ticks)
//   chan_en   per-channel run enable
//   tick      1-cycle pulse on accumulator carry
//   tick_sub  1-cycle pulse on carry into the sub-tap bit
//   tick_div  1-cycle pulse on every (div+1)th tick
//   tog       flips on every tick_div
module fpga_robots_game_ticks #(
  parameter int unsigned       NCHAN        = 4,
  parameter int unsigned       SEL_W        = 2,
  parameter int unsigned       ACC_W        = 19,
  parameter int unsigned       SUB_SHIFT    = 3,
  parameter int unsigned       DIV_W        = 8,
  parameter logic [ACC_W-1:0]  DEFAULT_STEP = ACC_W'(929),
  parameter logic [DIV_W-1:0]  DEFAULT_DIV  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [ACC_W-1:0] wr_step,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [NCHAN-1:0] chan_en,
  output logic [NCHAN-1:0] tick,
  output logic [NCHAN-1:0] tick_sub,
  output logic [NCHAN-1:0] tick_div,
  output logic [NCHAN-1:0] tog
);

  // Sub-tick tap bit: toggles 2^SUB_SHIFT times per accumulator wrap.
  localparam int unsigned B = ACC_W - SUB_SHIFT;

  logic [ACC_W-1:0] acc_q    [NCHAN];
  logic [ACC_W-1:0] acc_d    [NCHAN];
  logic [ACC_W-1:0] step_q   [NCHAN];
  logic [ACC_W-1:0] step_d   [NCHAN];
  logic [DIV_W-1:0] div_q    [NCHAN];
  logic [DIV_W-1:0] div_d    [NCHAN];
  logic [DIV_W-1:0] divctr_q [NCHAN];
  logic [DIV_W-1:0] divctr_d [NCHAN];
  logic [ACC_W:0]   nxt      [NCHAN];

  logic [NCHAN-1:0] tick_q, tick_d;
  logic [NCHAN-1:0] sub_q, sub_d;
  logic [NCHAN-1:0] tdiv_q, tdiv_d;
  logic [NCHAN-1:0] tog_q, tog_d;

  always_comb begin
    for (int unsigned i = 0; i < NCHAN; i++) begin
      nxt[i]      = {1'b0, acc_q[i]} + {1'b0, step_q[i]};
      acc_d[i]    = acc_q[i];
      step_d[i]   = step_q[i];
      div_d[i]    = div_q[i];
      divctr_d[i] = divctr_q[i];
      tick_d[i]   = 1'b0;
      sub_d[i]    = 1'b0;
      tdiv_d[i]   = 1'b0;
      tog_d[i]    = tog_q[i];
      // A write takes priority over running and silences the channel
      // for one cycle; the toggle is left untouched.
      if (wr_en && (wr_sel == SEL_W'(i))) begin
        step_d[i]   = wr_step;
        div_d[i]    = wr_div;
        acc_d[i]    = '0;
        divctr_d[i] = '0;
      end else if (chan_en[i]) begin
        acc_d[i]  = nxt[i][ACC_W-1:0];
        tick_d[i] = nxt[i][ACC_W];
        sub_d[i]  = nxt[i][B] ^ acc_q[i][B];
        if (nxt[i][ACC_W]) begin
          if (divctr_q[i] == div_q[i]) begin
            divctr_d[i] = '0;
            tdiv_d[i]   = 1'b1;
            tog_d[i]    = ~tog_q[i];
          end else begin
            divctr_d[i] = divctr_q[i] + DIV_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        acc_q[i]    <= '0;
        step_q[i]   <= DEFAULT_STEP;
        div_q[i]    <= DEFAULT_DIV;
        divctr_q[i] <= '0;
      end
      tick_q <= '0;
      sub_q  <= '0;
      tdiv_q <= '0;
      tog_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        acc_q[i]    <= acc_d[i];
        step_q[i]   <= step_d[i];
        div_q[i]    <= div_d[i];
        divctr_q[i] <= divctr_d[i];
      end
      tick_q <= tick_d;
      sub_q  <= sub_d;
      tdiv_q <= tdiv_d;
      tog_q  <= tog_d;
    end
  end

  assign tick     = tick_q;
  assign tick_sub = sub_q;
  assign tick_div = tdiv_q;
  assign tog      = tog_q;

endmodule
